// File: rtl/seven_seg_pkg.sv
// Shared glyphs, FSM states and mode encodings for the seven-segment driver.
// Optional leading-zero blanking is enabled with SEVEN_SEG_BLANK_EN.
package seven_seg_pkg;

  // Active-low glyphs, bit n = segment n (bit 6 = middle).
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1011000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/seven_seg_display_driver_glyph.sv
// Nibble to active-low seven-segment glyph lookup.
// Shared by the driver top; unaffected by SEVEN_SEG_BLANK_EN.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_BLANK;
    unique case (i_digit)
      4'h0: o_seg = GLYPH_0;
      4'h1: o_seg = GLYPH_1;
      4'h2: o_seg = GLYPH_2;
      4'h3: o_seg = GLYPH_3;
      4'h4: o_seg = GLYPH_4;
      4'h5: o_seg = GLYPH_5;
      4'h6: o_seg = GLYPH_6;
      4'h7: o_seg = GLYPH_7;
      4'h8: o_seg = GLYPH_8;
      4'h9: o_seg = GLYPH_9;
      4'hA: o_seg = GLYPH_A;
      4'hB: o_seg = GLYPH_B;
      4'hC: o_seg = GLYPH_C;
      4'hD: o_seg = GLYPH_D;
      4'hE: o_seg = GLYPH_E;
      4'hF: o_seg = GLYPH_F;
      default: o_seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_display_driver.sv
// Registered hex / double-dabble decimal seven-segment driver.
// Define SEVEN_SEG_BLANK_EN to blank leading zero digits.
module seven_seg_display_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_mode,
  output logic [7*DIGITS-1:0]   o_seven,
  output logic                  o_overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic [WIDTH-1:0]    val_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic [7*DIGITS-1:0] seven_q;
  logic                ovf_out_q;

  logic [BW-1:0]       adj_d;
  logic [7*DIGITS-1:0] glyph;
  logic [7*DIGITS-1:0] img_d;
  logic [WIDTH+BW-1:0] ext;
  logic                hex_ovf;

  // Zero-extend so hex overflow is simply "anything above the shown nibbles".
  assign ext     = {{BW{1'b0}}, i_value};
  assign hex_ovf = |ext[WIDTH+BW-1:BW];

  always_comb begin
    adj_d = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_glyph
    seven_seg_glyph u_glyph (
      .i_digit (bcd_q[4*g +: 4]),
      .o_seg   (glyph[7*g +: 7])
    );
  end

  always_comb begin
`ifdef SEVEN_SEG_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    img_d = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SEVEN_SEG_BLANK_EN
      if (k == 0 || bcd_q[4*k +: 4] != 4'd0)
        lead = 1'b0;
`endif
      if (ovf_q)
        img_d[7*k +: 7] = GLYPH_DASH;
`ifdef SEVEN_SEG_BLANK_EN
      else if (lead)
        img_d[7*k +: 7] = GLYPH_BLANK;
`endif
      else
        img_d[7*k +: 7] = glyph[7*k +: 7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      val_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      seven_q   <= '1;
      ovf_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (i_mode == MODE_DEC) begin
              val_q   <= i_value;
              bcd_q   <= '0;
              cnt_q   <= CW'(WIDTH);
              ovf_q   <= 1'b0;
              state_q <= CONV;
            end else begin
              bcd_q   <= ext[BW-1:0];
              ovf_q   <= hex_ovf;
              state_q <= LOAD;
            end
          end
        end
        CONV: begin
          {bcd_q, val_q} <= {adj_d[BW-2:0], val_q, 1'b0};
          ovf_q          <= ovf_q | adj_d[BW-1];
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_q <= LOAD;
        end
        LOAD: begin
          seven_q   <= img_d;
          ovf_out_q <= ovf_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_seven    = seven_q;
  assign o_overflow = ovf_out_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver (DIGITS=8, WIDTH=32).
// Expectations follow SEVEN_SEG_BLANK_EN the same way the design does.
module tb_seven_seg_display_driver;

`ifdef SEVEN_SEG_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] GDASH = 7'b0111111;
  localparam logic [6:0] GBLNK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_value = '0;
  logic        i_mode = 1'b0;
  logic [55:0] o_seven;
  logic        o_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_seg_display_driver #(.DIGITS(8), .WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_value    (i_value),
    .i_mode     (i_mode),
    .o_seven    (o_seven),
    .o_overflow (o_overflow)
  );

  function automatic logic [6:0] gl(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1011000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference: digits by plain division / nibble extraction.
  function automatic void model(input logic [31:0] v, input logic m,
                                output logic [55:0] s, output logic o);
    longint x = longint'(v);
    longint p = 1;
    int d[8];
    int top = 0;
    o = m ? (x >= 64'd100000000) : 1'b0;
    for (int k = 0; k < 8; k++) begin
      d[k] = m ? int'((x / p) % 10) : int'((x >> (4 * k)) & 15);
      p = p * 10;
      if (d[k] != 0) top = k;
    end
    for (int k = 0; k < 8; k++) begin
      if (o)                   s[7*k +: 7] = GDASH;
      else if (BLANK && k > top) s[7*k +: 7] = GBLNK;
      else                     s[7*k +: 7] = gl(d[k]);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic req(input logic [31:0] v, input logic m, output int lat);
    @(negedge clk);
    i_valid = 1'b1;
    i_value = v;
    i_mode  = m;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 0;
    while (!o_ready && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  typedef struct {
    logic [31:0] v;
    logic        m;
    logic [55:0] s;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vt[8];
  logic [6:0]  lz;
  logic [55:0] es, last;
  logic        eo;
  int          lat;
  logic [31:0] rv;
  logic        rm;

  initial begin
    lz = BLANK ? GBLNK : gl(0);
    vt[0] = '{32'hDEADBEEF, 1'b0,
              {gl(13), gl(14), gl(10), gl(13), gl(11), gl(14), gl(14), gl(15)},
              1'b0, 1};
    vt[1] = '{32'd12345, 1'b1,
              {lz, lz, lz, gl(1), gl(2), gl(3), gl(4), gl(5)}, 1'b0, 33};
    vt[2] = '{32'd99999999, 1'b1, {8{gl(9)}}, 1'b0, 33};
    vt[3] = '{32'd100000000, 1'b1, {8{GDASH}}, 1'b1, 33};
    vt[4] = '{32'h00000A0F, 1'b0,
              {lz, lz, lz, lz, lz, gl(10), gl(0), gl(15)}, 1'b0, 1};
    vt[5] = '{32'd0, 1'b1, {lz, lz, lz, lz, lz, lz, lz, gl(0)}, 1'b0, 33};
    vt[6] = '{32'd10000000, 1'b1, {gl(1), {7{gl(0)}}}, 1'b0, 33};
    vt[7] = '{32'h00000010, 1'b0,
              {lz, lz, lz, lz, lz, lz, gl(1), gl(0)}, 1'b0, 1};

    #12;
    chk("rst_seven", 64'(o_seven), 64'({56{1'b1}}));
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req(vt[i].v, vt[i].m, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_seven", i), 64'(o_seven), 64'(vt[i].s));
      chk($sformatf("vec%0d_ovf", i), 64'(o_overflow), 64'(vt[i].o));
    end
    last = vt[7].s;

    // Busy pulse is dropped; prior image held while converting.
    @(negedge clk);
    i_valid = 1'b1; i_value = 32'hFFFFFFFF; i_mode = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    i_valid = 1'b1; i_value = 32'd7; i_mode = 1'b0;
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("held_img", 64'(o_seven), 64'(last));
    chk("busy_ready", 64'(o_ready), 64'd0);
    lat = 0;
    while (!o_ready && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("ffff_lat", 64'(lat), 64'd27);
    chk("ffff_seven", 64'(o_seven), 64'({8{GDASH}}));
    chk("ffff_ovf", 64'(o_overflow), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queue_rdy", 64'(o_ready), 64'd1);
    chk("no_queue_img", 64'(o_seven), 64'({8{GDASH}}));
    req(32'h12, 1'b0, lat);
    model(32'h12, 1'b0, es, eo);
    chk("clr_seven", 64'(o_seven), 64'(es));
    chk("clr_ovf", 64'(o_overflow), 64'd0);

    // i_valid held through busy: second request taken on first IDLE edge.
    @(negedge clk);
    i_valid = 1'b1; i_value = 32'hA5; i_mode = 1'b0;
    @(posedge clk);
    #1 i_value = 32'h3C;
    @(posedge clk);
    #1;
    model(32'hA5, 1'b0, es, eo);
    chk("b2b_first", 64'(o_seven), 64'(es));
    chk("b2b_rdy_idle", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("b2b_taken", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1;
    model(32'h3C, 1'b0, es, eo);
    chk("b2b_second", 64'(o_seven), 64'(es));

    // Asynchronous reset in the middle of a decimal conversion.
    @(negedge clk);
    i_valid = 1'b1; i_value = 32'd987654; i_mode = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seven", 64'(o_seven), 64'({56{1'b1}}));
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    chk("mid_rst_ovf", 64'(o_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req(32'h0, 1'b0, lat);
    model(32'h0, 1'b0, es, eo);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_zero", 64'(o_seven), 64'(es));

    for (int i = 0; i < 40; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 0) rv = 32'd100000000 - 32'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      req(rv, rm, lat);
      model(rv, rm, es, eo);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), rm ? 64'd33 : 64'd1);
      chk($sformatf("rnd%0d_seven", i), 64'(o_seven), 64'(es));
      chk($sformatf("rnd%0d_ovf", i), 64'(o_overflow), 64'(eo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_driver.md
# seven_seg_display_driver

Parametrised, registered seven-segment display driver. It accepts a WIDTH-bit value over a valid/ready handshake and renders it across DIGITS active-low displays. The value is shown either as hexadecimal or as unsigned decimal; decimal uses iterative double-dabble, one bit per cycle. It sits between the CPU debug/register-file tap and the board's seven-segment pins. The previous image stays on the pins until a new conversion completes, so the display never flickers.

## Interface
Parameters:
- DIGITS, 8, number of seven-segment displays driven (1..16).
- WIDTH, 32, bit width of the input value (4..64).

Ports:
- i_clk  input  1  single clock; all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  request to display i_value.
- o_ready  output  1  high when IDLE; a request is accepted on an edge with i_valid && o_ready.
- i_value  input  WIDTH  value to display; sampled only on acceptance.
- i_mode  input  1  0 = hex, 1 = unsigned decimal; sampled only on acceptance.
- o_seven  output  7*DIGITS  segments, active-low (1 = dark). Digit k (0 = least significant) is bits [7k+6:7k]. Bit n drives segment n: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
- o_overflow  output  1  value did not fit in DIGITS digits for the latched mode.

## Operation
- States: IDLE, CONV, LOAD.
- IDLE → CONV on acceptance when i_mode=1. The value is latched, the 4*DIGITS-bit BCD accumulator is cleared, and the shift counter is set to WIDTH.
- IDLE → LOAD on acceptance when i_mode=0. Nibbles are latched directly.
- CONV, each cycle:
  - For every BCD digit >= 5, add 3.
  - Shift {bcd, value} left by 1 and decrement the counter.
  - A 1 shifted out of the top BCD digit sets the sticky overflow flag.
  - Leave CONV for LOAD when the counter reaches 0.
- LOAD: register all DIGITS glyphs and o_overflow, then go to IDLE.
- Hex overflow: any nonzero bit of i_value above bit 4*DIGITS-1.
- On overflow, every digit shows the dash glyph 0111111 (middle segment only).
- Glyphs:
  - 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000.
  - A-F: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Handshake: i_valid while o_ready=0 is ignored and not queued. i_valid held across busy cycles is accepted on the first IDLE edge.
- Reset (asynchronous, including mid-conversion):
  - o_seven all ones (dark), o_overflow 0, o_ready 1.
  - State IDLE; accumulator and counter cleared.

## Timing
- Acceptance edge = E0.
- Hex: o_seven/o_overflow update at E1; o_ready 0 during cycle E0–E1, 1 after E1.
- Decimal: WIDTH shift edges E1..E_WIDTH, outputs update at E_(WIDTH+1); o_ready low for WIDTH+1 cycles.
- A new request can be accepted on the same edge as the first IDLE cycle (back-to-back, no bubble beyond LOAD).
- Outputs are registered; no combinational path from i_value/i_mode to o_seven.

## Configuration
- SEVEN_SEG_BLANK_EN defined: leading-zero blanking.
  - Digits above the most-significant nonzero digit are dark (1111111).
  - Digit 0 is never blanked; a value of 0 shows a single "0".
  - Applies in both modes; does not apply on overflow (all dashes).
- Undefined: all DIGITS digits are always shown, including leading zeros.

## Structure
- Package seven_seg_pkg holds:
  - glyph constants GLYPH_0..GLYPH_F, GLYPH_DASH, GLYPH_BLANK;
  - state enum typedef (IDLE, CONV, LOAD);
  - MODE_HEX/MODE_DEC constants.
- Sub-module seven_seg_glyph: combinational 4-bit → 7-bit active-low lookup, instantiated DIGITS times via generate.
- The top holds the FSM, counter, BCD accumulator, blanking logic and output registers.

## Test plan
- Reset, then DIGITS=8, WIDTH=32, hex 0xDEADBEEF → at E1: digit0 0001110 (F), digit7 0100001 (d); o_overflow 0; o_ready back to 1 after E1.
- Decimal 12345, blank enabled → at E33: digits0..4 = 0010010, 0011001, 0110000, 0100100, 1111001. Digits5..7 = 1111111 (blank disabled: 1000000). o_ready low for 33 cycles.
- Decimal 99999999 → all digits 0010000, overflow 0. Decimal 100000000 → all digits 0111111, o_overflow 1.
- Decimal 0xFFFFFFFF, then i_valid with 7 pulsed while busy → pulse ignored; display shows all dashes. The next accepted request clears o_overflow.
- Assert i_rst_n low at cycle 10 of a decimal conversion → immediately o_seven all ones, o_ready 1, o_overflow 0. After release, hex 0x0 with blank enabled → digit0 1000000, others 1111111.
